pg_out_stream: RTL
==================

# pg_out_stream

Sum-recovery stage of the prefix adder datapath: it consumes per-bit generate/propagate vectors, resolves carries with an internal prefix tree, and emits registered sum words. Operands wider than `WIDTH` are streamed as multi-beat transfers, least-significant beat first, with the carry chained between beats. Input and output use valid/ready handshakes, with a 2-entry output buffer so upstream can stream at full rate.

## Interface
- `WIDTH`, 8, bits per beat (≥2).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  beat offered.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_gen`  in  WIDTH  per-bit generate, x&y.
- `in_prop`  in  WIDTH  per-bit propagate, x^y.
- `in_first`  in  1  beat is least-significant beat of an operand.
- `in_last`  in  1  beat is most-significant beat of an operand.
- `c_in`  in  1  operand carry-in, sampled only on `in_first` beats.
- `out_valid`  out  1  result beat available.
- `out_ready`  in  1  result beat consumed when `out_valid && out_ready`.
- `sum`  out  WIDTH  sum bits of the beat.
- `c_out`  out  1  carry out of the beat's MSB.
- `out_last`  out  1  copy of `in_last` for this beat.
- `beat_idx`  out  8  beat index within operand, 0 on first beat, saturates at 255.
- `ovf`  out  1  signed overflow, valid with `out_last` (see Configuration).

## Operation
- Beat carry-in `cb = in_first ? c_in : carry_q`.
- Prefix tree (Kogge-Stone, log2 levels) over (`in_gen`, `in_prop`) with `cb` folded in at bit 0 gives carries `c[i]` into each bit `i`.
- `sum[i] = in_prop[i] ^ c[i]`; `c_out` = carry out of bit `WIDTH-1`.
- On each accepted beat: `carry_q <= c_out`; `beat_q <= in_first ? 0 : sat255(beat_q+1)`; a result entry is pushed.
- Beat with `in_first && in_last`: single-beat operand, `beat_idx = 0`.
- No protocol checking: a non-first beat after a `last` beat chains from `carry_q`. Carry and index state are not altered between beats.
- Output buffer is a 2-entry FIFO with occupancy `cnt` ∈ {0,1,2}. `in_ready = (cnt != 2)`, taken from registered state only, with no combinational path from `out_ready`. `out_valid = (cnt != 0)`. The head entry drives `sum`, `c_out`, `out_last`, `beat_idx`, `ovf`.
- Simultaneous push and pop at `cnt == 1`: `cnt` stays 1, head advances, and the new entry becomes head next cycle.
- At `cnt == 2`, no push is possible. A pop makes `cnt = 1`, and `in_ready` rises the next cycle.
- Head data holds stable while `out_valid && !out_ready`.

## Timing
- Latency: an accepted beat appears at the head on the next rising edge if the FIFO was empty, otherwise behind earlier entries.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- Reset, asynchronous assert, at any time including mid-operand: `cnt = 0`, `carry_q = 0`, `beat_q = 0`, `in_ready = 1`, `out_valid = 0`, and `sum`, `c_out`, `out_last`, `beat_idx`, `ovf` all 0. Partial operands are discarded.
- Reset release is synchronous to `clk`. The first beat may be accepted on the first edge after deassertion.

## Configuration
- `PG_OUT_OVF_EN` defined: each entry stores `ovf = c[WIDTH-1] ^ c_out` when `in_last`, else 0. This adds one FIFO bit per entry.
- Not defined: `ovf` is tied to 0 and no storage is added. The port is still present.

## Test plan
- Single beat, `WIDTH=8`, x=0x5A, y=0x3C: `in_gen=0x18`, `in_prop=0x66`, `c_in=0`, `first=last=1` -> next cycle `sum=0x96`, `c_out=0`, `beat_idx=0`, `out_last=1`.
- Two-beat 0x01FF+0x0001: beat0 gen=0x01, prop=0xFE, `c_in=0`, `first=1`; beat1 gen=0x00, prop=0x01, `last=1` -> `sum` 0x00 (`c_out=1`, idx 0), then 0x02 (`c_out=0`, idx 1, `out_last=1`).
- Overflow with `PG_OUT_OVF_EN` defined, 0x7F+0x01: gen=0x01, prop=0x7E, single beat -> `sum=0x80`, `ovf=1`. Without the macro -> `ovf=0`.
- Backpressure: `out_ready=0` while 3 beats are offered back-to-back -> 2 accepted, `in_ready=0` from the cycle after the 2nd accept. Then `out_ready=1` -> all 3 emitted in order, head held stable while stalled.
- Full-rate streaming: 16 single-beat ops with `out_ready=1` -> one result per cycle, and `in_ready` never drops.
- Reset mid-operand: after beat0 of 0x01FF+0x0001 is accepted, pulse `rst_n` low -> `out_valid=0`, `cnt=0`. A new single-beat 0x01+0x01 (gen=0x01, prop=0x00, `c_in=0`) then gives `sum=0x02` with no stale carry.

Source files
------------

// File: rtl/pg_out_stream_if.sv
// Handshake bundle for pg_out_stream: generate/propagate beats in, registered sum beats out.
interface pg_out_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_gen;
  logic [WIDTH-1:0] in_prop;
  logic             in_first;
  logic             in_last;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             out_last;
  logic [7:0]       beat_idx;
  logic             ovf;

  modport slave (
    input  in_valid, in_gen, in_prop, in_first, in_last, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, out_last, beat_idx, ovf
  );

  modport master (
    output in_valid, in_gen, in_prop, in_first, in_last, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, out_last, beat_idx, ovf
  );
endinterface

// File: rtl/pg_out_stream.sv
// Kogge-Stone sum recovery with beat-chained carry; PG_OUT_OVF_EN adds a stored signed-overflow flag.
// Result at FIFO head one cycle after accept; 2-entry buffer, in_ready = !full from registered state only.
module pg_out_stream #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  pg_out_stream_if.slave pg_io
);
  localparam int LVLS = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             last;
    logic [7:0]       idx;
`ifdef PG_OUT_OVF_EN
    logic             ovf;
`endif
  } entry_t;

  logic             carry_q, carry_d;
  logic [7:0]       beat_q, beat_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             wr_ptr_q, rd_ptr_q;
  entry_t           mem_q [2];
  entry_t           entry_d;
  entry_t           head;

  logic             cb;
  logic [LVLS:0][WIDTH-1:0] g_l;
  logic [LVLS:0][WIDTH-1:0] p_l;
  logic [WIDTH-1:0] c;
  logic             c_msb_out;
  logic             push, pop;

  assign cb = pg_io.in_first ? pg_io.c_in : carry_q;

  // Carry-in is folded into bit 0's generate so the tree yields true carries directly.
  always_comb begin
    g_l    = '0;
    p_l    = '0;
    g_l[0] = pg_io.in_gen;
    g_l[0][0] = pg_io.in_gen[0] | (pg_io.in_prop[0] & cb);
    p_l[0] = pg_io.in_prop;
    for (int lv = 0; lv < LVLS; lv++) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (b >= (1 << lv)) begin
          g_l[lv+1][b] = g_l[lv][b] | (p_l[lv][b] & g_l[lv][b-(1<<lv)]);
          p_l[lv+1][b] = p_l[lv][b] & p_l[lv][b-(1<<lv)];
        end else begin
          g_l[lv+1][b] = g_l[lv][b];
          p_l[lv+1][b] = p_l[lv][b];
        end
      end
    end
  end

  always_comb begin
    c    = '0;
    c[0] = cb;
    for (int i = 1; i < WIDTH; i++) begin
      c[i] = g_l[LVLS][i-1];
    end
  end

  assign c_msb_out = g_l[LVLS][WIDTH-1];

  assign push = pg_io.in_valid && pg_io.in_ready;
  assign pop  = pg_io.out_valid && pg_io.out_ready;

  always_comb begin
    entry_d       = '0;
    entry_d.sum   = pg_io.in_prop ^ c;
    entry_d.c_out = c_msb_out;
    entry_d.last  = pg_io.in_last;
    entry_d.idx   = beat_d;
`ifdef PG_OUT_OVF_EN
    entry_d.ovf   = pg_io.in_last & (c[WIDTH-1] ^ c_msb_out);
`endif
  end

  always_comb begin
    carry_d = carry_q;
    beat_d  = pg_io.in_first ? 8'd0 :
              (beat_q == 8'hFF) ? 8'hFF : beat_q + 8'd1;
    if (push) begin
      carry_d = c_msb_out;
    end
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q  <= 1'b0;
      beat_q   <= 8'd0;
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      if (push) begin
        beat_q          <= beat_d;
        mem_q[wr_ptr_q] <= entry_d;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign pg_io.in_ready  = (cnt_q != 2'd2);
  assign pg_io.out_valid = (cnt_q != 2'd0);
  assign pg_io.sum       = head.sum;
  assign pg_io.c_out     = head.c_out;
  assign pg_io.out_last  = head.last;
  assign pg_io.beat_idx  = head.idx;
`ifdef PG_OUT_OVF_EN
  assign pg_io.ovf       = head.ovf;
`else
  assign pg_io.ovf       = 1'b0;
`endif

endmodule
